// File: rtl/gcd_host_if.sv
// Stream, engine and result signals of the GCD host, bundled for port connection.
// The slave modport is the host's view; master is the view of whatever surrounds it.
interface gcd_host_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_b;
    logic             eng_start;
    logic [WIDTH-1:0] eng_dout;
    logic             eng_done;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    modport slave (
        input  op_valid, op_a, op_b, eng_dout, eng_done, res_ready,
        output op_ready, eng_a, eng_b, eng_start, res_valid, res_data, res_err, busy
    );

    modport master (
        output op_valid, op_a, op_b, eng_dout, eng_done, res_ready,
        input  op_ready, eng_a, eng_b, eng_start, res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/gcd_host.sv
// Host initiator for a subtraction GCD engine: issues operand pairs, collects results
// in order through a small FIFO, bypasses zero operands and times out stuck transactions.
module gcd_host #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       reset_i,
    gcd_host_if.slave  bus_io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] eng_a_q, eng_a_d;
    logic [WIDTH-1:0] eng_b_q, eng_b_d;
    logic [CW-1:0]    tmo_q, tmo_d;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;

    logic             accept_s, push_s, pop_s, not_empty_s;
    logic [WIDTH:0]   push_entry_s;

    assign not_empty_s      = (cnt_q != '0);
    assign bus_io.op_ready  = (state_q == IDLE) && (cnt_q < CNT_FULL) && !reset_i;
    assign accept_s         = bus_io.op_valid && bus_io.op_ready;
    assign pop_s            = not_empty_s && bus_io.res_ready;

    assign bus_io.eng_a     = eng_a_q;
    assign bus_io.eng_b     = eng_b_q;
    assign bus_io.eng_start = (state_q == ISSUE);
    assign bus_io.busy      = (state_q != IDLE);
    assign bus_io.res_valid = not_empty_s;
    assign bus_io.res_data  = not_empty_s ? mem_q[rd_q][WIDTH-1:0] : '0;
    assign bus_io.res_err   = not_empty_s ? mem_q[rd_q][WIDTH] : 1'b0;

    // Next-state, operand latch and FIFO push decode.
    always_comb begin
        state_d      = state_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
        tmo_d        = tmo_q;
        push_s       = 1'b0;
        push_entry_s = '0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if ((bus_io.op_a != '0) && (bus_io.op_b != '0)) begin
                        eng_a_d = bus_io.op_a;
                        eng_b_d = bus_io.op_b;
                        state_d = ISSUE;
                    end else begin
                        // A zero operand would spin the engine forever; answer locally.
                        push_s       = 1'b1;
                        push_entry_s = {(bus_io.op_a == '0) && (bus_io.op_b == '0),
                                        bus_io.op_a | bus_io.op_b};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                if (bus_io.eng_done) begin
                    push_s       = 1'b1;
                    push_entry_s = {1'b0, bus_io.eng_dout};
                    state_d      = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    push_s       = 1'b1;
                    push_entry_s = {1'b1, {WIDTH{1'b0}}};
                    state_d      = IDLE;
                end else begin
                    tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, engine operands and timeout counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            eng_a_q <= '0;
            eng_b_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            eng_a_q <= eng_a_d;
            eng_b_q <= eng_b_d;
            tmo_q   <= tmo_d;
        end
    end

    // FIFO storage; contents past the pointers are never observed, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_q] <= push_entry_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_s) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_host.sv
// Directed bench for gcd_host with a behavioural GCD engine answering four cycles after start.
module tb_gcd_host;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gcd_host_if #(.WIDTH(W)) ifc ();

    gcd_host #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (ifc)
    );

    int total = 0;
    int bad   = 0;

    bit           eng_auto  = 1'b1;
    bit           auto_done = 1'b0;
    logic [W-1:0] auto_val  = '0;
    int           rem       = 0;
    int           start_cnt = 0;
    logic         man_done  = 1'b0;
    logic [W-1:0] man_dout  = '0;

    assign ifc.eng_done = auto_done | man_done;
    assign ifc.eng_dout = auto_done ? auto_val : man_dout;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: result strobe in the fourth cycle after the start cycle.
    always @(posedge clk) begin
        #1;
        if (ifc.eng_start) start_cnt++;
        if (reset) begin
            rem = 0;
            auto_done = 1'b0;
        end else if (eng_auto && ifc.eng_start) begin
            rem = 4;
            auto_val = gcd_ref(ifc.eng_a, ifc.eng_b);
            auto_done = 1'b0;
        end else if (rem > 0) begin
            rem = rem - 1;
            auto_done = (rem == 0);
        end else begin
            auto_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        ifc.op_valid = 1'b1;
        ifc.op_a = a;
        ifc.op_b = b;
        while (!ifc.op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", {31'd0, ifc.op_ready}, 32'd1);
        @(negedge clk);
        ifc.op_valid = 1'b0;
    endtask

    task automatic wait_auto_done();
        int n;
        n = 0;
        while (!auto_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", {31'd0, auto_done}, 32'd1);
    endtask

    task automatic pop_one();
        ifc.res_ready = 1'b1;
        @(negedge clk);
        ifc.res_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         err;
        bit           eng;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [W-1:0] exp_q[$];

        vecs[0] = '{a: 16'd48,    b: 16'd18,  data: 16'd6,  err: 1'b0, eng: 1'b1};
        vecs[1] = '{a: 16'd0,     b: 16'd7,   data: 16'd7,  err: 1'b0, eng: 1'b0};
        vecs[2] = '{a: 16'd0,     b: 16'd0,   data: 16'd0,  err: 1'b1, eng: 1'b0};
        vecs[3] = '{a: 16'd9,     b: 16'd0,   data: 16'd9,  err: 1'b0, eng: 1'b0};
        vecs[4] = '{a: 16'd1071,  b: 16'd462, data: 16'd21, err: 1'b0, eng: 1'b1};
        vecs[5] = '{a: 16'd65535, b: 16'd1,   data: 16'd1,  err: 1'b0, eng: 1'b1};

        ifc.op_valid = 1'b0;
        ifc.op_a = '0;
        ifc.op_b = '0;
        ifc.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_ready", {31'd0, ifc.op_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, ifc.res_valid}, 32'd0);
        chk("rst_res_data", {16'd0, ifc.res_data}, 32'd0);
        chk("rst_res_err", {31'd0, ifc.res_err}, 32'd0);
        chk("rst_eng_start", {31'd0, ifc.eng_start}, 32'd0);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_eng_a", {16'd0, ifc.eng_a}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_op_ready", {31'd0, ifc.op_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt;
            send(vecs[i].a, vecs[i].b);
            if (vecs[i].eng) begin
                chk("vec_start", {31'd0, ifc.eng_start}, 32'd1);
                chk("vec_eng_a", {16'd0, ifc.eng_a}, {16'd0, vecs[i].a});
                chk("vec_eng_b", {16'd0, ifc.eng_b}, {16'd0, vecs[i].b});
                wait_auto_done();
                chk("vec_busy_wait", {31'd0, ifc.busy}, 32'd1);
                chk("vec_pre_valid", {31'd0, ifc.res_valid}, 32'd0);
                @(negedge clk);
            end else begin
                chk("vec_no_start", {31'd0, ifc.eng_start}, 32'd0);
            end
            chk("vec_valid", {31'd0, ifc.res_valid}, 32'd1);
            chk("vec_data", {16'd0, ifc.res_data}, {16'd0, vecs[i].data});
            chk("vec_err", {31'd0, ifc.res_err}, {31'd0, vecs[i].err});
            pop_one();
            chk("vec_empty", {31'd0, ifc.res_valid}, 32'd0);
            chk("vec_busy", {31'd0, ifc.busy}, 32'd0);
            chk("vec_starts", start_cnt - s0, {31'd0, vecs[i].eng});
        end

        // Timeout with a silent engine, then a late done that must be ignored.
        eng_auto = 1'b0;
        send(16'd5, 16'd3);
        repeat (16) @(negedge clk);
        chk("tmo_pre_valid", {31'd0, ifc.res_valid}, 32'd0);
        chk("tmo_pre_busy", {31'd0, ifc.busy}, 32'd1);
        @(negedge clk);
        chk("tmo_valid", {31'd0, ifc.res_valid}, 32'd1);
        chk("tmo_data", {16'd0, ifc.res_data}, 32'd0);
        chk("tmo_err", {31'd0, ifc.res_err}, 32'd1);
        chk("tmo_busy", {31'd0, ifc.busy}, 32'd0);
        @(negedge clk);
        man_done = 1'b1;
        man_dout = 16'd77;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("late_done_data", {16'd0, ifc.res_data}, 32'd0);
        chk("late_done_err", {31'd0, ifc.res_err}, 32'd1);
        pop_one();
        chk("late_done_count", {31'd0, ifc.res_valid}, 32'd0);

        // Done and timeout on the same edge: done wins.
        send(16'd21, 16'd14);
        repeat (16) @(negedge clk);
        man_done = 1'b1;
        man_dout = 16'd7;
        @(negedge clk);
        man_done = 1'b0;
        chk("race_valid", {31'd0, ifc.res_valid}, 32'd1);
        chk("race_data", {16'd0, ifc.res_data}, 32'd7);
        chk("race_err", {31'd0, ifc.res_err}, 32'd0);
        pop_one();

        // Backpressure: four results fill the FIFO and hold off a fifth pair.
        eng_auto = 1'b1;
        send(16'd12, 16'd8);
        send(16'd35, 16'd21);
        send(16'd17, 16'd17);
        send(16'd100, 16'd75);
        repeat (8) @(negedge clk);
        ifc.op_valid = 1'b1;
        ifc.op_a = 16'd0;
        ifc.op_b = 16'd5;
        @(negedge clk);
        chk("bp_ready_low", {31'd0, ifc.op_ready}, 32'd0);
        chk("bp_head", {16'd0, ifc.res_data}, 32'd4);
        @(negedge clk);
        chk("bp_ready_held", {31'd0, ifc.op_ready}, 32'd0);
        pop_one();
        chk("bp_ready_up", {31'd0, ifc.op_ready}, 32'd1);
        exp_q = '{16'd7, 16'd17, 16'd25, 16'd5};
        ifc.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain", {16'd0, ifc.res_data}, {16'd0, exp_q[k]});
            @(negedge clk);
            ifc.op_valid = 1'b0;
        end
        ifc.res_ready = 1'b0;
        chk("bp_empty", {31'd0, ifc.res_valid}, 32'd0);

        // Pop and engine push on the same edge with three entries buffered.
        send(16'd0, 16'd1);
        send(16'd0, 16'd2);
        send(16'd0, 16'd3);
        send(16'd48, 16'd18);
        wait_auto_done();
        ifc.res_ready = 1'b1;
        @(negedge clk);
        ifc.res_ready = 1'b0;
        exp_q = '{16'd2, 16'd3, 16'd6};
        for (int k = 0; k < 3; k++) begin
            chk("sim_valid", {31'd0, ifc.res_valid}, 32'd1);
            chk("sim_order", {16'd0, ifc.res_data}, {16'd0, exp_q[k]});
            pop_one();
        end
        chk("sim_empty", {31'd0, ifc.res_valid}, 32'd0);

        // Reset while waiting on the engine.
        eng_auto = 1'b0;
        send(16'd0, 16'd9);
        send(16'd40, 16'd8);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_op_ready", {31'd0, ifc.op_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, ifc.res_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, ifc.res_data}, 32'd0);
        chk("mid_rst_eng_a", {16'd0, ifc.eng_a}, 32'd0);
        chk("mid_rst_eng_b", {16'd0, ifc.eng_b}, 32'd0);
        chk("mid_rst_start", {31'd0, ifc.eng_start}, 32'd0);
        man_done = 1'b1;
        man_dout = 16'd99;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("stray_done", {31'd0, ifc.res_valid}, 32'd0);
        eng_auto = 1'b1;
        send(16'd30, 16'd12);
        chk("post_rst_start", {31'd0, ifc.eng_start}, 32'd1);
        wait_auto_done();
        @(negedge clk);
        chk("post_rst_valid", {31'd0, ifc.res_valid}, 32'd1);
        chk("post_rst_data", {16'd0, ifc.res_data}, 32'd6);
        chk("post_rst_err", {31'd0, ifc.res_err}, 32'd0);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gcd_host.md
Name: gcd_host

Overview:
- Host-side initiator for the clock-specified GCD engine.
- Accepts operand pairs on a valid/ready input stream and issues each pair to the engine with a start pulse.
- Captures the engine's result on its done strobe and returns results in order through a small result FIFO with valid/ready output.
- Short-circuits zero operands, which would never terminate in the subtraction engine, and bounds every transaction with a timeout.

Parameters:
- WIDTH, 16, operand and result width
- DEPTH, 4, result FIFO entries (power of 2, >=2)
- TIMEOUT, 1024, maximum WAIT cycles before the host abandons a transaction

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  operand pair available
- op_ready  out  1  host accepts operand pair this cycle
- op_a  in  WIDTH  operand a
- op_b  in  WIDTH  operand b
- eng_a  out  WIDTH  operand a driven to engine
- eng_b  out  WIDTH  operand b driven to engine
- eng_start  out  1  one-cycle start pulse to engine
- eng_dout  in  WIDTH  engine result
- eng_done  in  1  engine result valid, single-cycle strobe
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer takes FIFO head
- res_data  out  WIDTH  FIFO head result
- res_err  out  1  FIFO head error flag
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE; FIFO is emptied; timeout counter is cleared.
  - eng_a, eng_b, eng_start, res_valid, res_data, res_err and busy are all 0.
  - op_ready is 0 during the reset cycle.
  - Reset mid-transaction drops the in-flight operand pair; a later eng_done is ignored.
- Accept: a transfer occurs when op_valid & op_ready at a clock edge.
  - op_ready = (state==IDLE) & (fifo_count < DEPTH) & ~reset.
  - Space for the result is therefore always reserved before an operand pair is accepted.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE, accepted pair with op_a!=0 and op_b!=0: latch eng_a=op_a, eng_b=op_b, go to ISSUE.
  - IDLE, accepted pair with either operand 0 (bypass): write FIFO {data=op_a|op_b, err=(op_a==0 & op_b==0)} at the accept edge. State stays IDLE and eng_start is not asserted.
  - ISSUE: eng_start=1 for exactly this one cycle; next state is WAIT; the timeout counter is cleared.
  - WAIT, eng_done=1: write FIFO {data=eng_dout, err=0} at that edge and go to IDLE.
  - WAIT, no eng_done, counter==TIMEOUT-1: write FIFO {data=0, err=1} and go to IDLE. Otherwise the counter increments.
  - If eng_done and timeout occur in the same cycle, eng_done wins.
- eng_a and eng_b hold their values from ISSUE until the next accepted non-zero pair; they do not change during WAIT.
- eng_done outside WAIT is ignored.
- Latency:
  - Accept at edge T: eng_start is high in cycle T+1.
  - eng_done sampled at edge D: res_valid rises in cycle D+1 if the FIFO was empty.
  - Bypass: res_valid is high the cycle after the accept.
  - Minimum back-to-back issue interval is 3 cycles.
- FIFO:
  - Synchronous, DEPTH entries, WIDTH+1 bits per entry (data and err).
  - res_data and res_err show the head when res_valid=1 and are 0 when the FIFO is empty.
  - A pop occurs on res_valid & res_ready. A push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH. The count runs 0..DEPTH, and the full condition is count==DEPTH.
  - No push ever occurs on a full FIFO; this is guaranteed by the accept rule.
- Results leave the FIFO strictly in accept order, including bypass and timeout entries.
- Timeout counter width is clog2(TIMEOUT+1); it saturates and never wraps.

Test Plan:
- Basic transaction: op (48,18); engine model asserts done with 6 four cycles after start. Required: exactly one eng_start pulse with eng_a=48 and eng_b=18; res_valid=1 with res_data=6 and res_err=0 one cycle after done; busy low again.
- Zero bypass:
  - op (0,7): no eng_start; res_data=7, err=0 in the next cycle.
  - op (0,0): res_data=0, err=1.
  - op (9,0): res_data=9, err=0.
- Timeout, with TIMEOUT=16 and an engine that never asserts done: res_data=0 with err=1 is pushed at the 16th WAIT edge. A done injected 2 cycles later is ignored and the FIFO count is unchanged.
- Backpressure, with res_ready=0 and four non-zero ops (12,8), (35,21), (17,17), (100,75):
  - op_ready stays low after the 4th result is buffered and the 5th op is held.
  - Pulsing res_ready for one cycle pops 4; op_ready rises in the next cycle.
  - Drained order is 4, 7, 17, 25.
- Simultaneous events: FIFO holds 3 entries, res_ready=1, and eng_done lands in the same cycle. The count stays 3 and the head advances correctly. Done and timeout in the same cycle records eng_dout with err=0.
- Reset mid-WAIT: assert reset for 1 cycle. All outputs are 0 afterwards, the FIFO is empty and the state is IDLE. A subsequent eng_done creates no result, and a new op (30,12) completes with res_data=6.
